tx_fifo_feeder: RTL

Byte buffer and sequencer that sits directly upstream of the UART transmitter. It accepts bytes from the application on a write strobe and stores them in a small FIFO. It then presents them one at a time to the transmitter through its Tx_En_Sig / Tx_Data / Tx_Done_Sig handshake, so producers can burst bytes without waiting for each serial frame to finish.

---
 rtl/tx_fifo_feeder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/tx_fifo_feeder.sv
// tx_fifo_feeder: byte FIFO that sequences stored bytes into a UART transmitter
// over the Tx_En_Sig / Tx_Data / Tx_Done_Sig handshake. Define
// TX_FIFO_FEEDER_DROP_CNT_EN to build the saturating overflow counter on Drop_Cnt.
module tx_fifo_feeder #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                CLK,
  input  logic                RST_n,
  input  logic                Wr_En_Sig,
  input  logic [7:0]          Wr_Data,
  output logic                Full_Sig,
  output logic                Empty_Sig,
  output logic [DEPTH_LOG2:0] Count,
  output logic                Busy_Sig,
  input  logic                Tx_Done_Sig,
  output logic                Tx_En_Sig,
  output logic [7:0]          Tx_Data,
  output logic [7:0]          Drop_Cnt
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  state_t                state_q, state_d;
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  tx_en_q, tx_en_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  pop;
  logic                  wr_fire;

  assign Full_Sig  = (count_q == FULL_CNT);
  assign Empty_Sig = (count_q == '0);
  assign Count     = count_q;
  assign Busy_Sig  = (state_q != IDLE) || !Empty_Sig;
  assign Tx_En_Sig = tx_en_q;
  assign Tx_Data   = tx_data_q;

  // Fullness uses the pre-edge count, so a write during a pop while full is lost.
  assign wr_fire = Wr_En_Sig && !Full_Sig;

  always_ff @(posedge CLK) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q] <= Wr_Data;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    end
    unique case ({wr_fire, pop})
      2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= IDLE;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!Empty_Sig) state_d = LOAD;
      LOAD:    state_d = SEND;
      SEND:    if (Tx_Done_Sig) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop       = 1'b0;
    tx_en_d   = tx_en_q;
    tx_data_d = tx_data_q;
    unique case (state_q)
      LOAD: begin
        pop       = 1'b1;
        tx_en_d   = 1'b1;
        tx_data_d = mem_q[rd_ptr_q];
      end
      SEND:    if (Tx_Done_Sig) tx_en_d = 1'b0;
      default: tx_en_d = 1'b0;
    endcase
  end

`ifdef TX_FIFO_FEEDER_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      drop_cnt_q <= '0;
    end else if (Wr_En_Sig && Full_Sig && (drop_cnt_q != '1)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign Drop_Cnt = drop_cnt_q;
`else
  assign Drop_Cnt = '0;
`endif

endmodule
